// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN accelerator control path:
// sequencer states, default memory-port widths and bank-select codes.
package cnn_pkg;

    localparam int CNN_ADDR_W = 12;
    localparam int CNN_DATA_W = 20;
    localparam int CNN_SEL_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } seq_state_e;

    // Bank codes every engine uses on csel; BANK_NONE is the parked value.
    localparam logic [CNN_SEL_W-1:0] BANK_NONE   = 3'd0;
    localparam logic [CNN_SEL_W-1:0] BANK_IFMAP  = 3'd1;
    localparam logic [CNN_SEL_W-1:0] BANK_WEIGHT = 3'd2;
    localparam logic [CNN_SEL_W-1:0] BANK_ACT    = 3'd3;
    localparam logic [CNN_SEL_W-1:0] BANK_POOL   = 3'd4;
    localparam logic [CNN_SEL_W-1:0] BANK_FLAT   = 3'd5;

endpackage

// File: rtl/cnn_mem_mux.sv
// Grant-indexed combinational mux onto the single shared memory port.
// With no valid grant every shared output is parked at zero.
module cnn_mem_mux
    import cnn_pkg::*;
#(
    parameter int NUM_LAYERS = 3,
    parameter int ADDR_W     = CNN_ADDR_W,
    parameter int DATA_W     = CNN_DATA_W,
    parameter int SEL_W      = CNN_SEL_W
) (
    input  logic                         gnt_vld,
    input  logic [1:0]                   gnt_idx,
    input  logic [NUM_LAYERS-1:0]        eng_crd,
    input  logic [NUM_LAYERS-1:0]        eng_cwr,
    input  logic [NUM_LAYERS*SEL_W-1:0]  eng_csel,
    input  logic [NUM_LAYERS*ADDR_W-1:0] eng_caddr_rd,
    input  logic [NUM_LAYERS*ADDR_W-1:0] eng_caddr_wr,
    input  logic [NUM_LAYERS*DATA_W-1:0] eng_cdata_wr,
    output logic                         crd,
    output logic                         cwr,
    output logic [SEL_W-1:0]             csel,
    output logic [ADDR_W-1:0]            caddr_rd,
    output logic [ADDR_W-1:0]            caddr_wr,
    output logic [DATA_W-1:0]            cdata_wr
);

    always_comb begin
        crd      = 1'b0;
        cwr      = 1'b0;
        csel     = SEL_W'(BANK_NONE);
        caddr_rd = '0;
        caddr_wr = '0;
        cdata_wr = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (gnt_vld && (gnt_idx == 2'(i))) begin
                crd      = eng_crd[i];
                cwr      = eng_cwr[i];
                csel     = eng_csel[i*SEL_W +: SEL_W];
                caddr_rd = eng_caddr_rd[i*ADDR_W +: ADDR_W];
                caddr_wr = eng_caddr_wr[i*ADDR_W +: ADDR_W];
                cdata_wr = eng_cdata_wr[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Launches the layer engines in order, waits for each done pulse under a
// per-layer watchdog, and grants the shared memory port to the active engine.
module cnn_layer_sequencer
    import cnn_pkg::*;
#(
    parameter int NUM_LAYERS = 3,
    parameter int ADDR_W     = CNN_ADDR_W,
    parameter int DATA_W     = CNN_DATA_W,
    parameter int SEL_W      = CNN_SEL_W,
    parameter int TIMEOUT    = 1000000,
    parameter int WDOG_W     = 20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ready,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [1:0]                   layer_idx,
    output logic [31:0]                  run_cycles,
    output logic [NUM_LAYERS-1:0]        eng_start,
    input  logic [NUM_LAYERS-1:0]        eng_done,
    input  logic [NUM_LAYERS-1:0]        eng_crd,
    input  logic [NUM_LAYERS-1:0]        eng_cwr,
    input  logic [NUM_LAYERS*SEL_W-1:0]  eng_csel,
    input  logic [NUM_LAYERS*ADDR_W-1:0] eng_caddr_rd,
    input  logic [NUM_LAYERS*ADDR_W-1:0] eng_caddr_wr,
    input  logic [NUM_LAYERS*DATA_W-1:0] eng_cdata_wr,
    output logic [DATA_W-1:0]            eng_cdata_rd,
    output logic                         crd,
    output logic                         cwr,
    output logic [SEL_W-1:0]             csel,
    output logic [ADDR_W-1:0]            caddr_rd,
    output logic [ADDR_W-1:0]            caddr_wr,
    output logic [DATA_W-1:0]            cdata_wr,
    input  logic [DATA_W-1:0]            cdata_rd
);

    seq_state_e        state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic [31:0]       cyc_q, cyc_d;
    logic [31:0]       run_cycles_q, run_cycles_d;
    logic              cur_done, last_layer, wdog_expired, gnt_vld;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            wdog_q       <= '0;
            cyc_q        <= '0;
            run_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wdog_q       <= wdog_d;
            cyc_q        <= cyc_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    // Only the granted engine's done pulse is looked at, and only in RUN.
    assign cur_done     = eng_done[idx_q];
    assign last_layer   = (idx_q == 2'(NUM_LAYERS - 1));
    assign wdog_expired = (wdog_q == WDOG_W'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wdog_d       = wdog_q;
        cyc_d        = cyc_q;
        run_cycles_d = run_cycles_q;
        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (ready) begin
                    state_d = ST_LAUNCH;
                    idx_d   = '0;
                    cyc_d   = '0;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_RUN;
                wdog_d  = '0;
                cyc_d   = sat_inc32(cyc_q);
            end
            ST_RUN: begin
                wdog_d = wdog_q + 1'b1;
                cyc_d  = sat_inc32(cyc_q);
                if (cur_done) begin
                    if (last_layer) begin
                        state_d      = ST_DONE;
                        run_cycles_d = sat_inc32(cyc_q);
                    end else begin
                        state_d = ST_GAP;
                        idx_d   = idx_q + 1'b1;
                    end
                end else if (wdog_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_GAP: state_d = ST_LAUNCH;
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status decodes straight from registered state, so reset clears them at once.
    assign gnt_vld      = (state_q == ST_LAUNCH) || (state_q == ST_RUN);
    assign busy         = gnt_vld || (state_q == ST_GAP);
    assign done         = (state_q == ST_DONE);
    assign err          = (state_q == ST_ERR);
    assign layer_idx    = idx_q;
    assign run_cycles   = run_cycles_q;
    assign eng_start    = (state_q == ST_LAUNCH) ? (NUM_LAYERS'(1) << idx_q) : '0;
    assign eng_cdata_rd = cdata_rd;

    cnn_mem_mux #(
        .NUM_LAYERS (NUM_LAYERS),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .SEL_W      (SEL_W)
    ) u_mem_mux (
        .gnt_vld      (gnt_vld),
        .gnt_idx      (idx_q),
        .eng_crd      (eng_crd),
        .eng_cwr      (eng_cwr),
        .eng_csel     (eng_csel),
        .eng_caddr_rd (eng_caddr_rd),
        .eng_caddr_wr (eng_caddr_wr),
        .eng_cdata_wr (eng_cdata_wr),
        .crd          (crd),
        .cwr          (cwr),
        .csel         (csel),
        .caddr_rd     (caddr_rd),
        .caddr_wr     (caddr_wr),
        .cdata_wr     (cdata_wr)
    );

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: one instance with the default
// watchdog for the nominal run, one with TIMEOUT=16 for watchdog cases.
module tb_cnn_layer_sequencer;

    localparam int NL = 3;
    localparam int AW = 12;
    localparam int DW = 20;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ready = 1'b0;
    logic [NL-1:0] eng_done = '0;
    logic [NL-1:0] eng_crd;
    logic [NL-1:0] eng_cwr;
    logic [NL*SW-1:0] eng_csel;
    logic [NL*AW-1:0] eng_caddr_rd;
    logic [NL*AW-1:0] eng_caddr_wr;
    logic [NL*DW-1:0] eng_cdata_wr;
    logic [DW-1:0] cdata_rd;

    logic          a_busy, a_done, a_err, a_crd, a_cwr;
    logic [1:0]    a_layer_idx;
    logic [31:0]   a_run_cycles;
    logic [NL-1:0] a_eng_start;
    logic [DW-1:0] a_eng_cdata_rd, a_cdata_wr;
    logic [SW-1:0] a_csel;
    logic [AW-1:0] a_caddr_rd, a_caddr_wr;

    logic          w_busy, w_done, w_err, w_crd, w_cwr;
    logic [1:0]    w_layer_idx;
    logic [31:0]   w_run_cycles;
    logic [NL-1:0] w_eng_start;
    logic [DW-1:0] w_eng_cdata_rd, w_cdata_wr;
    logic [SW-1:0] w_csel;
    logic [AW-1:0] w_caddr_rd, w_caddr_wr;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cnn_layer_sequencer #(
        .NUM_LAYERS(NL), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW),
        .TIMEOUT(1000000), .WDOG_W(20)
    ) dut (
        .clk(clk), .reset(reset), .ready(ready),
        .busy(a_busy), .done(a_done), .err(a_err),
        .layer_idx(a_layer_idx), .run_cycles(a_run_cycles),
        .eng_start(a_eng_start), .eng_done(eng_done),
        .eng_crd(eng_crd), .eng_cwr(eng_cwr), .eng_csel(eng_csel),
        .eng_caddr_rd(eng_caddr_rd), .eng_caddr_wr(eng_caddr_wr),
        .eng_cdata_wr(eng_cdata_wr), .eng_cdata_rd(a_eng_cdata_rd),
        .crd(a_crd), .cwr(a_cwr), .csel(a_csel),
        .caddr_rd(a_caddr_rd), .caddr_wr(a_caddr_wr),
        .cdata_wr(a_cdata_wr), .cdata_rd(cdata_rd)
    );

    cnn_layer_sequencer #(
        .NUM_LAYERS(NL), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW),
        .TIMEOUT(16), .WDOG_W(5)
    ) dut_wd (
        .clk(clk), .reset(reset), .ready(ready),
        .busy(w_busy), .done(w_done), .err(w_err),
        .layer_idx(w_layer_idx), .run_cycles(w_run_cycles),
        .eng_start(w_eng_start), .eng_done(eng_done),
        .eng_crd(eng_crd), .eng_cwr(eng_cwr), .eng_csel(eng_csel),
        .eng_caddr_rd(eng_caddr_rd), .eng_caddr_wr(eng_caddr_wr),
        .eng_cdata_wr(eng_cdata_wr), .eng_cdata_rd(w_eng_cdata_rd),
        .crd(w_crd), .cwr(w_cwr), .csel(w_csel),
        .caddr_rd(w_caddr_rd), .caddr_wr(w_caddr_wr),
        .cdata_wr(w_cdata_wr), .cdata_rd(cdata_rd)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges; returns 1 time unit after the last edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish by 200000");
        $fatal(1, "bench timed out");
    end

    initial begin
        // Fixed engine bus drives: engine0, engine1, engine2 each distinct.
        eng_crd      = 3'b110;
        eng_cwr      = 3'b101;
        eng_csel     = {3'd5, 3'd2, 3'd1};
        eng_caddr_rd = {12'h777, 12'hABC, 12'h123};
        eng_caddr_wr = {12'h333, 12'h0F0, 12'h055};
        eng_cdata_wr = {20'h55555, 20'hABCDE, 20'h12345};
        cdata_rd     = 20'hBEEF0;

        // Reset state
        tick(3);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_err", a_err, 0);
        chk("rst_layer_idx", a_layer_idx, 0);
        chk("rst_run_cycles", a_run_cycles, 0);
        chk("rst_eng_start", a_eng_start, 0);
        chk("rst_crd_cwr", {a_crd, a_cwr}, 0);
        chk("rst_csel", a_csel, 0);
        chk("rst_caddr_rd", a_caddr_rd, 0);
        chk("rst_cdata_wr", a_cdata_wr, 0);
        reset = 1'b0;
        tick(2);
        chk("idle_busy", a_busy, 0);

        // Nominal run: done 10, 20, 5 cycles after each start
        ready = 1'b1; tick(1); ready = 1'b0;
        chk("l0_launch_start", a_eng_start, 3'b001);
        chk("l0_launch_busy", a_busy, 1);
        chk("l0_launch_idx", a_layer_idx, 0);
        chk("l0_crd", a_crd, 0);
        chk("l0_cwr", a_cwr, 1);
        chk("l0_csel", a_csel, 3'd1);
        chk("l0_caddr_rd", a_caddr_rd, 12'h123);
        chk("l0_caddr_wr", a_caddr_wr, 12'h055);
        chk("l0_cdata_wr", a_cdata_wr, 20'h12345);
        chk("cdata_rd_bcast", a_eng_cdata_rd, 20'hBEEF0);
        tick(3);
        eng_done = 3'b100; tick(1); eng_done = '0;
        chk("spurious_idx", a_layer_idx, 0);
        chk("spurious_busy", a_busy, 1);
        chk("spurious_start", a_eng_start, 0);
        chk("spurious_caddr_rd", a_caddr_rd, 12'h123);
        tick(6);
        eng_done = 3'b001; tick(1); eng_done = '0;
        chk("gap0_busy", a_busy, 1);
        chk("gap0_idx", a_layer_idx, 1);
        chk("gap0_start", a_eng_start, 0);
        chk("gap0_crd_cwr", {a_crd, a_cwr}, 0);
        chk("gap0_caddr_rd", a_caddr_rd, 0);
        chk("gap0_csel", a_csel, 0);
        chk("gap0_cdata_wr", a_cdata_wr, 0);
        tick(1);
        chk("l1_launch_start", a_eng_start, 3'b010);
        chk("l1_crd", a_crd, 1);
        chk("l1_caddr_rd", a_caddr_rd, 12'hABC);
        tick(20);
        eng_done = 3'b010; tick(1); eng_done = '0;
        chk("gap1_start", a_eng_start, 0);
        chk("gap1_idx", a_layer_idx, 2);
        tick(1);
        chk("l2_launch_start", a_eng_start, 3'b100);
        chk("l2_csel", a_csel, 3'd5);
        tick(5);
        eng_done = 3'b100; tick(1); eng_done = '0;
        chk("done_pulse", a_done, 1);
        chk("done_busy", a_busy, 0);
        chk("done_run_cycles", a_run_cycles, 38);
        chk("done_crd", a_crd, 0);
        tick(1);
        chk("idle_done_low", a_done, 0);
        chk("idle_idx", a_layer_idx, 0);
        chk("idle_crd", a_crd, 0);
        chk("idle_caddr_rd", a_caddr_rd, 0);
        chk("idle_run_cycles_held", a_run_cycles, 38);

        // Watchdog with TIMEOUT=16: engine1 never finishes
        reset = 1'b1; tick(1); reset = 1'b0; tick(1);
        ready = 1'b1; tick(1); ready = 1'b0;
        tick(2);
        eng_done = 3'b001; tick(1); eng_done = '0;
        tick(1);
        chk("wd_l1_start", w_eng_start, 3'b010);
        tick(16);
        chk("wd_run16_err", w_err, 0);
        chk("wd_run16_busy", w_busy, 1);
        tick(1);
        chk("wd_err", w_err, 1);
        chk("wd_busy", w_busy, 0);
        chk("wd_crd_cwr", {w_crd, w_cwr}, 0);
        chk("wd_caddr_rd", w_caddr_rd, 0);
        chk("wd_idx", w_layer_idx, 1);
        tick(3);
        chk("wd_err_sticky", w_err, 1);
        ready = 1'b1; tick(1); ready = 1'b0;
        chk("wd_restart_err", w_err, 0);
        chk("wd_restart_start", w_eng_start, 3'b001);
        chk("wd_restart_busy", w_busy, 1);

        // Done in RUN cycle 16 wins over the timeout
        tick(16);
        eng_done = 3'b001; tick(1); eng_done = '0;
        chk("tie_err", w_err, 0);
        chk("tie_busy", w_busy, 1);
        chk("tie_idx", w_layer_idx, 1);
        tick(1);
        chk("tie_l1_start", w_eng_start, 3'b010);
        ready = 1'b1; tick(1); ready = 1'b0;
        chk("ready_busy_start", w_eng_start, 0);
        chk("ready_busy_idx", w_layer_idx, 1);

        // Reset during layer-1 RUN
        reset = 1'b1; tick(1); reset = 1'b0; tick(1);
        ready = 1'b1; tick(1); ready = 1'b0;
        tick(1);
        eng_done = 3'b001; tick(1); eng_done = '0;
        tick(2);
        chk("mid_pre_crd", a_crd, 1);
        chk("mid_pre_idx", a_layer_idx, 1);
        reset = 1'b1;
        #2;
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_crd", a_crd, 0);
        chk("mid_rst_caddr_rd", a_caddr_rd, 0);
        chk("mid_rst_idx", a_layer_idx, 0);
        chk("mid_rst_start", a_eng_start, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        ready = 1'b1; tick(1); ready = 1'b0;
        chk("mid_restart_start", a_eng_start, 3'b001);
        chk("mid_restart_idx", a_layer_idx, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
